// File: rtl/sie_rx_line_monitor_if.sv
// rtl/sie_rx_line_monitor_if.sv - sample-in and forward-out handshake bundle for the SIE receive line monitor
interface sie_rx_line_monitor_if;
    logic [1:0] RxWireDataIn;
    logic       RxWireDataWEn;
    logic       SIERxRdyOut;
    logic       processRxBitRdyIn;
    logic       processRxBitsWEn;
    logic [1:0] RxBitsOut;

    modport master (
        output RxWireDataIn, RxWireDataWEn, processRxBitRdyIn,
        input  SIERxRdyOut, processRxBitsWEn, RxBitsOut
    );

    modport slave (
        input  RxWireDataIn, RxWireDataWEn, processRxBitRdyIn,
        output SIERxRdyOut, processRxBitsWEn, RxBitsOut
    );
endinterface

// File: rtl/sie_rx_line_monitor.sv
// rtl/sie_rx_line_monitor.sv - SIE receive line monitor: connect/disconnect debounce, resume detect, sample forwarding
module sie_rx_line_monitor #(
    parameter int                 CNT_W           = 8,
    parameter logic [CNT_W-1:0]   CONNECT_WAIT    = 8'd100,
    parameter logic [CNT_W-1:0]   DISCONNECT_WAIT = 8'd100,
    parameter logic [CNT_W-1:0]   RESUME_WAIT     = 8'd20,
    parameter bit                 EARLY_RDY       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    sie_rx_line_monitor_if.slave  bus,
    output logic [1:0]            connectState,
    output logic                  connectEventOut,
    output logic                  disconnectEventOut,
    output logic                  resumeDetectOut,
    input  logic                  forceDisconnectIn
);

    typedef enum logic [2:0] {
        DISCONNECT, WAIT_FS_CONN, WAIT_LS_CONN, CONN_FS, CONN_LS, WAIT_FS_DISC, WAIT_LS_DISC
    } link_t;

    typedef enum logic [1:0] {WAIT_BIT, CHK, FWD_WAIT, FWD} ctrl_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    link_t            link;
    ctrl_t            ctrl;
    logic [1:0]       sample;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] resumeCount;
    logic [CNT_W-1:0] cntInc;
    logic [CNT_W-1:0] resInc;
    logic             fsSide;
    logic             forwarding;
    logic [1:0]       jSym;
    logic [1:0]       kSym;
    link_t            connLink;
    link_t            discLink;

    assign cntInc = (count == CNT_MAX) ? count : count + CNT_ONE;
    assign resInc = (resumeCount == CNT_MAX) ? resumeCount : resumeCount + CNT_ONE;

    // FS and LS differ only in which line state is J; everything else is shared.
    assign fsSide     = (link == WAIT_FS_CONN) || (link == CONN_FS) || (link == WAIT_FS_DISC);
    assign jSym       = fsSide ? 2'b10 : 2'b01;
    assign kSym       = fsSide ? 2'b01 : 2'b10;
    assign connLink   = fsSide ? CONN_FS : CONN_LS;
    assign discLink   = fsSide ? WAIT_FS_DISC : WAIT_LS_DISC;
    assign forwarding = (link == CONN_FS) || (link == CONN_LS) ||
                        (link == WAIT_FS_DISC) || (link == WAIT_LS_DISC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link                 <= DISCONNECT;
            ctrl                 <= WAIT_BIT;
            sample               <= 2'b00;
            count                <= '0;
            resumeCount          <= '0;
            connectState         <= 2'b00;
            connectEventOut      <= 1'b0;
            disconnectEventOut   <= 1'b0;
            resumeDetectOut      <= 1'b0;
            bus.SIERxRdyOut      <= 1'b1;
            bus.processRxBitsWEn <= 1'b0;
            bus.RxBitsOut        <= 2'b00;
        end else begin
            connectEventOut    <= 1'b0;
            disconnectEventOut <= 1'b0;
            resumeDetectOut    <= 1'b0;
            if (forceDisconnectIn) begin
                link                 <= DISCONNECT;
                ctrl                 <= WAIT_BIT;
                count                <= '0;
                resumeCount          <= '0;
                connectState         <= 2'b00;
                disconnectEventOut   <= (connectState != 2'b00);
                bus.SIERxRdyOut      <= 1'b1;
                bus.processRxBitsWEn <= 1'b0;
            end else begin
                case (ctrl)
                    WAIT_BIT: begin
                        if (bus.RxWireDataWEn && bus.SIERxRdyOut) begin
                            sample          <= bus.RxWireDataIn;
                            bus.SIERxRdyOut <= 1'b0;
                            ctrl            <= CHK;
                        end
                    end
                    CHK: begin
                        case (link)
                            DISCONNECT: begin
                                if (sample == 2'b10 || sample == 2'b01) begin
                                    if (CONNECT_WAIT <= CNT_ONE) begin
                                        link            <= (sample == 2'b10) ? CONN_FS : CONN_LS;
                                        connectState    <= sample;
                                        connectEventOut <= 1'b1;
                                        count           <= '0;
                                    end else begin
                                        link  <= (sample == 2'b10) ? WAIT_FS_CONN : WAIT_LS_CONN;
                                        count <= CNT_ONE;
                                    end
                                end
                            end
                            WAIT_FS_CONN, WAIT_LS_CONN: begin
                                if (sample == jSym) begin
                                    if (cntInc >= CONNECT_WAIT) begin
                                        link            <= connLink;
                                        connectState    <= jSym;
                                        connectEventOut <= 1'b1;
                                        count           <= '0;
                                    end else begin
                                        count <= cntInc;
                                    end
                                end else begin
                                    link  <= DISCONNECT;
                                    count <= '0;
                                end
                            end
                            CONN_FS, CONN_LS: begin
                                if (sample == 2'b00) begin
                                    resumeCount <= '0;
                                    if (DISCONNECT_WAIT <= CNT_ONE) begin
                                        link               <= DISCONNECT;
                                        connectState       <= 2'b00;
                                        disconnectEventOut <= 1'b1;
                                        count              <= '0;
                                    end else begin
                                        link  <= discLink;
                                        count <= CNT_ONE;
                                    end
                                end else if (sample == kSym) begin
                                    // Stop at the threshold so a long K run reports once.
                                    if (resumeCount < RESUME_WAIT) begin
                                        resumeCount <= resInc;
                                        if (resInc == RESUME_WAIT) resumeDetectOut <= 1'b1;
                                    end
                                end else begin
                                    resumeCount <= '0;
                                end
                            end
                            WAIT_FS_DISC, WAIT_LS_DISC: begin
                                if (sample == 2'b00) begin
                                    if (cntInc >= DISCONNECT_WAIT) begin
                                        link               <= DISCONNECT;
                                        connectState       <= 2'b00;
                                        disconnectEventOut <= 1'b1;
                                        count              <= '0;
                                    end else begin
                                        count <= cntInc;
                                    end
                                end else begin
                                    link  <= connLink;
                                    count <= '0;
                                end
                            end
                            default: begin
                                link  <= DISCONNECT;
                                count <= '0;
                            end
                        endcase
                        // Forwarding follows the link state the sample arrived in.
                        if (forwarding) begin
                            ctrl <= FWD_WAIT;
                        end else begin
                            bus.SIERxRdyOut <= 1'b1;
                            ctrl            <= WAIT_BIT;
                        end
                    end
                    FWD_WAIT: begin
                        if (bus.processRxBitRdyIn) begin
                            bus.RxBitsOut        <= sample;
                            bus.processRxBitsWEn <= 1'b1;
                            if (EARLY_RDY) bus.SIERxRdyOut <= 1'b1;
                            ctrl <= FWD;
                        end
                    end
                    FWD: begin
                        bus.processRxBitsWEn <= 1'b0;
                        // With early ready a strobe may land here and must not be lost.
                        if (EARLY_RDY && bus.RxWireDataWEn && bus.SIERxRdyOut) begin
                            sample          <= bus.RxWireDataIn;
                            bus.SIERxRdyOut <= 1'b0;
                            ctrl            <= CHK;
                        end else begin
                            bus.SIERxRdyOut <= 1'b1;
                            ctrl            <= WAIT_BIT;
                        end
                    end
                    default: begin
                        bus.SIERxRdyOut <= 1'b1;
                        ctrl            <= WAIT_BIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sie_rx_line_monitor.md
Name: sie_rx_line_monitor

Overview:
Parametrised successor to the SIE receive front end. It accepts 2-bit line-state samples from the wire-sampling stage and detects connect and disconnect per speed with configurable debounce times. In connected states it forwards samples to the bit-processing stage over a ready/write handshake. New features: resume (K-state) detection, connect/disconnect event pulses, forced disconnect, and an optional early-ready mode.

Parameters:
CNT_W, 8, width of debounce/resume counters; all counters saturate at all-ones
CONNECT_WAIT, 8'd100, consecutive J samples required to declare connect (1..2^CNT_W-1)
DISCONNECT_WAIT, 8'd100, consecutive SE0 samples required to declare disconnect (1..2^CNT_W-1)
RESUME_WAIT, 8'd20, consecutive K samples while connected to flag resume (1..2^CNT_W-1)
EARLY_RDY, 0, 1 = SIERxRdyOut re-asserts on the same edge as processRxBitsWEn

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
RxWireDataIn  in  2  line state sample {D+,D-}: SE0=00, 10=FS J/LS K, 01=LS J/FS K
RxWireDataWEn  in  1  sample strobe; honoured only while SIERxRdyOut=1
SIERxRdyOut  out  1  ready for next sample
processRxBitRdyIn  in  1  downstream ready
processRxBitsWEn  out  1  one-cycle forward strobe
RxBitsOut  out  2  forwarded sample, valid with processRxBitsWEn
connectState  out  2  00 disconnected, 01 low speed, 10 full speed
connectEventOut  out  1  one-cycle pulse on entry to a connected state
disconnectEventOut  out  1  one-cycle pulse on entry to disconnected from a connected/wait-disconnect state
resumeDetectOut  out  1  one-cycle pulse, resume detected
forceDisconnectIn  in  1  synchronous force to disconnected

Behaviour:
- Reset (async, immediate): connectState=00, RxBitsOut=00, processRxBitsWEn=0, SIERxRdyOut=1, all event pulses=0, counters=0, link state DISCONNECT, control FSM WAIT_BIT.
- Link states: DISCONNECT, WAIT_FS_CONN, WAIT_LS_CONN, CONN_FS, CONN_LS, WAIT_FS_DISC, WAIT_LS_DISC.
- Control FSM: WAIT_BIT, CHK, FWD_WAIT, FWD.
  - WAIT_BIT: on RxWireDataWEn=1, latch sample, drop SIERxRdyOut, go to CHK.
  - CHK, link DISCONNECT/WAIT_*_CONN: update link state, SIERxRdyOut=1, go to WAIT_BIT. No forwarding. Sample-to-ready latency is 2 edges.
  - CHK, link CONN_*/WAIT_*_DISC: update link state, go to FWD_WAIT.
  - FWD_WAIT: hold until processRxBitRdyIn=1. On that edge: RxBitsOut=sample, processRxBitsWEn=1, go to FWD. If EARLY_RDY=1, SIERxRdyOut=1 on the same edge.
  - FWD: processRxBitsWEn=0, SIERxRdyOut=1, go to WAIT_BIT.
- Connect:
  - DISCONNECT: sample 10 → WAIT_FS_CONN, count=1. Sample 01 → WAIT_LS_CONN, count=1. SE0/11 → stay.
  - WAIT_x_CONN: matching J sample increments count. A non-matching sample → DISCONNECT, count=0.
  - When count reaches CONNECT_WAIT: link CONN_x, connectState=10/01, connectEventOut pulses. Both take effect on the CHK edge. CONNECT_WAIT=1 connects on the first J.
- Disconnect:
  - CONN_x with SE0 sample → WAIT_x_DISC, count=1. Each further SE0 increments count.
  - Any non-SE0 sample in WAIT_x_DISC → CONN_x, count=0.
  - When count reaches DISCONNECT_WAIT: DISCONNECT, connectState=00, disconnectEventOut pulses.
  - All samples in these states, SE0 included, are still forwarded.
- Resume:
  - In CONN_x, consecutive K samples (01 FS, 10 LS) increment resumeCount. Any other sample clears it.
  - resumeDetectOut pulses once when resumeCount reaches RESUME_WAIT. resumeCount then holds (no repeat pulse) until a non-K sample arrives.
  - resumeCount clears on leaving CONN_x.
- forceDisconnectIn=1 takes highest priority at the clock edge:
  - link → DISCONNECT, connectState=00, counters=0, processRxBitsWEn=0, SIERxRdyOut=1, FSM → WAIT_BIT.
  - An in-flight sample is dropped.
  - disconnectEventOut pulses only if connectState was non-zero.
- Counters saturate; no wrap.
- Event pulses are registered, exactly one cycle wide, never simultaneous.
- RxWireDataWEn while SIERxRdyOut=0 is ignored.

Test Plan:
1. Async reset mid-FWD_WAIT: assert rst between clock edges → all outputs at reset values before the next edge. SIERxRdyOut=1, connectState=00.
2. FS connect, CONNECT_WAIT=4: four 10 samples → connectState=10 and one connectEventOut pulse on the 4th CHK edge. Three 10 samples then 00 → connectState stays 00, no pulse.
3. LS connected, processRxBitRdyIn held 0 for 5 cycles after sample 01 → no processRxBitsWEn and SIERxRdyOut=0 throughout. Release → one WEn pulse with RxBitsOut=01, ready 1 edge later (EARLY_RDY=0) or same edge (EARLY_RDY=1).
4. DISCONNECT_WAIT=3, FS connected: SE0,SE0,10 → stays 10, all three forwarded. Then SE0×3 → connectState=00, one disconnectEventOut.
5. RESUME_WAIT=5, FS connected: eight 01 samples → exactly one resumeDetectOut pulse, on the 5th. Then 10 followed by five 01 → a second pulse.
6. forceDisconnectIn in WAIT_LS_DISC with a sample in FWD_WAIT → no WEn, connectState=00, one disconnectEventOut. Force asserted while already disconnected → no pulse.
